// File: rtl/filter_switch_sequencer.sv
// Drives the RF low-pass filter relays from the DDS frequency word.
// Band changes are debounced, then run a mute/break/select/make/settle sequence.
module filter_switch_sequencer #(
    parameter int STABLE_CYC = 16,
    parameter int MUTE_CYC   = 64,
    parameter int BREAK_CYC  = 2048,
    parameter int SETTLE_CYC = 8192,
    parameter int CNT_W      = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_freqw,
    input  logic        i_hold,
    output logic [2:0]  o_filter_select,
    output logic        o_relay_en,
    output logic        o_dac_mute,
    output logic        o_busy,
    output logic        o_switch_done
);

    typedef enum logic [2:0] {INIT, IDLE, QUAL, MUTE, BREAK, MAKE, SETTLE} state_t;

    localparam logic [CNT_W-1:0] STABLE_N    = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_CYC - 1);
    localparam logic [CNT_W-1:0] BREAK_LAST  = CNT_W'(BREAK_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           r_state;
    logic [2:0]       r_curBand;
    logic [2:0]       r_candBand;
    logic [2:0]       r_tgtBand;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_stateNext;
    logic [2:0]       w_band;
    logic [2:0]       w_curBandNext;
    logic [2:0]       w_candBandNext;
    logic [2:0]       w_tgtBandNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_cntInc;
    logic [2:0]       w_selNext;
    logic             w_doneNext;
    logic             w_relayNext;
    logic             w_muteNext;
    logic             w_busyNext;

    // Equal-to-edge values fall into the higher band, hence strict less-than.
    always_comb begin
        w_band = 3'd7;
        if (i_freqw < 32'd523449139) w_band = 3'd6;
        if (i_freqw < 32'd289462899) w_band = 3'd5;
        if (i_freqw < 32'd171351299) w_band = 3'd4;
        if (i_freqw < 32'd101558080) w_band = 3'd3;
        if (i_freqw < 32'd63977116)  w_band = 3'd2;
        if (i_freqw < 32'd40712710)  w_band = 3'd1;
        if (i_freqw < 32'd26396153)  w_band = 3'd0;
    end

    assign w_cntInc = r_cnt + CNT_W'(1);

    always_comb begin
        w_stateNext    = r_state;
        w_curBandNext  = r_curBand;
        w_candBandNext = r_candBand;
        w_tgtBandNext  = r_tgtBand;
        w_cntNext      = r_cnt;
        w_selNext      = o_filter_select;
        w_doneNext     = 1'b0;
        case (r_state)
            INIT: begin
                w_tgtBandNext = w_band;
                w_cntNext     = '0;
                w_stateNext   = BREAK;
            end
            IDLE: begin
                if (!i_hold && (w_band != r_curBand)) begin
                    w_candBandNext = w_band;
                    if (STABLE_CYC == 1) begin
                        w_tgtBandNext = w_band;
                        w_cntNext     = '0;
                        w_stateNext   = MUTE;
                    end else begin
                        w_cntNext   = CNT_W'(1);
                        w_stateNext = QUAL;
                    end
                end
            end
            QUAL: begin
                if (w_band == r_candBand) begin
                    if (w_cntInc == STABLE_N) begin
                        w_tgtBandNext = r_candBand;
                        w_cntNext     = '0;
                        w_stateNext   = MUTE;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end else if (w_band == r_curBand) begin
                    w_stateNext = IDLE;
                end else begin
                    w_candBandNext = w_band;
                    w_cntNext      = CNT_W'(1);
                end
            end
            MUTE: begin
                if (r_cnt == MUTE_LAST) begin
                    w_cntNext   = '0;
                    w_stateNext = BREAK;
                end else begin
                    w_cntNext = w_cntInc;
                end
            end
            BREAK: begin
                if (r_cnt == BREAK_LAST) begin
                    w_cntNext     = '0;
                    w_selNext     = 3'd7 - r_tgtBand;
                    w_curBandNext = r_tgtBand;
                    w_stateNext   = MAKE;
                end else begin
                    w_cntNext = w_cntInc;
                end
            end
            MAKE: begin
                w_cntNext   = '0;
                w_stateNext = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cntNext   = '0;
                    w_doneNext  = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_cntNext = w_cntInc;
                end
            end
            default: w_stateNext = INIT;
        endcase

        // Outputs are decoded from the next state so they stay registered.
        w_relayNext = (w_stateNext == IDLE) || (w_stateNext == QUAL) ||
                      (w_stateNext == MUTE) || (w_stateNext == SETTLE);
        w_muteNext  = !((w_stateNext == IDLE) || (w_stateNext == QUAL));
        w_busyNext  = (w_stateNext != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= INIT;
            r_curBand       <= 3'd0;
            r_candBand      <= 3'd0;
            r_tgtBand       <= 3'd0;
            r_cnt           <= '0;
            o_filter_select <= 3'd7;
            o_relay_en      <= 1'b0;
            o_dac_mute      <= 1'b1;
            o_busy          <= 1'b1;
            o_switch_done   <= 1'b0;
        end else begin
            r_state         <= w_stateNext;
            r_curBand       <= w_curBandNext;
            r_candBand      <= w_candBandNext;
            r_tgtBand       <= w_tgtBandNext;
            r_cnt           <= w_cntNext;
            o_filter_select <= w_selNext;
            o_relay_en      <= w_relayNext;
            o_dac_mute      <= w_muteNext;
            o_busy          <= w_busyNext;
            o_switch_done   <= w_doneNext;
        end
    end

endmodule

// File: tb/tb_filter_switch_sequencer.sv
// Bench for filter_switch_sequencer: directed vectors plus random stimulus
// compared against a timeline model of the switch sequence.
module tb_filter_switch_sequencer;

    localparam int STABLE = 2;
    localparam int MUTE   = 3;
    localparam int BRK    = 4;
    localparam int SETTLE = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] freqw = 32'd8947849;
    logic        hold = 1'b0;
    logic [2:0]  o_filter_select;
    logic        o_relay_en;
    logic        o_dac_mute;
    logic        o_busy;
    logic        o_switch_done;

    int checks = 0;
    int errors = 0;

    int unsigned edgesTab [7] = '{26396153, 40712710, 63977116, 101558080,
                                  171351299, 289462899, 523449139};

    typedef struct {
        logic [31:0] freq;
        logic [2:0]  expSel;
    } vec_t;
    vec_t vecs [16];

    // Model: edge count, applied band, and the sequence expressed as a start edge.
    int mN, mCur, mTgt, mCand, mCnt, mT0;
    bit mInit, mSeq, mQual, mDone;

    filter_switch_sequencer #(
        .STABLE_CYC(STABLE), .MUTE_CYC(MUTE), .BREAK_CYC(BRK),
        .SETTLE_CYC(SETTLE), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_freqw(freqw), .i_hold(hold),
        .o_filter_select(o_filter_select), .o_relay_en(o_relay_en),
        .o_dac_mute(o_dac_mute), .o_busy(o_busy), .o_switch_done(o_switch_done)
    );

    always #5 clk = ~clk;

    function automatic int bandOf(input logic [31:0] f);
        int b = 0;
        for (int k = 0; k < 7; k++) if (f >= edgesTab[k]) b++;
        return b;
    endfunction

    task automatic modelReset();
        mN = 0; mInit = 1; mSeq = 0; mQual = 0; mDone = 0;
        mCur = 0; mTgt = 0; mCand = 0; mCnt = 0; mT0 = 0;
    endtask

    task automatic startSeq();
        mQual = 0; mSeq = 1; mT0 = mN; mTgt = mCand;
    endtask

    task automatic modelStep(input logic [31:0] f, input logic h);
        int b;
        b = bandOf(f);
        mN++;
        mDone = 0;
        if (mInit) begin
            mInit = 0; mSeq = 1; mTgt = b; mT0 = mN - MUTE;
        end else if (mSeq) begin
            if (mN - mT0 == MUTE + BRK) mCur = mTgt;
            if (mN - mT0 == MUTE + BRK + 1 + SETTLE) begin
                mSeq = 0; mDone = 1;
            end
        end else if (mQual) begin
            if (b == mCand) begin
                mCnt++;
                if (mCnt == STABLE) startSeq();
            end else if (b == mCur) begin
                mQual = 0;
            end else begin
                mCand = b; mCnt = 1;
            end
        end else if (!h && b != mCur) begin
            mQual = 1; mCand = b; mCnt = 1;
            if (mCnt == STABLE) startSeq();
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [2:0] eSel;
        logic eRel, eMute, eBusy, eDone;
        int k;
        if (mInit) begin
            eSel = 3'd7; eRel = 0; eMute = 1; eBusy = 1; eDone = 0;
        end else begin
            k     = mN - mT0;
            eMute = mSeq;
            eRel  = !(mSeq && k >= MUTE && k <= MUTE + BRK);
            eBusy = mSeq || mQual;
            eSel  = 3'(7 - mCur);
            eDone = mDone;
        end
        checks++;
        if ({o_filter_select, o_relay_en, o_dac_mute, o_busy, o_switch_done} !==
            {eSel, eRel, eMute, eBusy, eDone}) begin
            errors++;
            $display("[TB] FAIL %s edge=%0d: got sel=%0d relay=%b mute=%b busy=%b done=%b, want sel=%0d relay=%b mute=%b busy=%b done=%b",
                     tag, mN, o_filter_select, o_relay_en, o_dac_mute, o_busy, o_switch_done,
                     eSel, eRel, eMute, eBusy, eDone);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] f, input logic h);
        freqw = f;
        hold  = h;
    endtask

    task automatic tick(input string tag);
        modelStep(freqw, hold);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, " sel"},   int'(o_filter_select), 7);
        checkVal({tag, " relay"}, int'(o_relay_en), 0);
        checkVal({tag, " mute"},  int'(o_dac_mute), 1);
        checkVal({tag, " busy"},  int'(o_busy), 1);
        checkVal({tag, " done"},  int'(o_switch_done), 0);
    endtask

    task automatic powerUp(input string tag);
        for (int e = 1; e <= 12; e++) begin
            tick(tag);
            if (e == 5)  checkVal({tag, " relay@5"}, int'(o_relay_en), 0);
            if (e == 6)  checkVal({tag, " relay@6"}, int'(o_relay_en), 1);
            if (e == 10) checkVal({tag, " done@10"}, int'(o_switch_done), 0);
            if (e == 11) checkVal({tag, " done@11"}, int'(o_switch_done), 1);
            if (e == 12) checkVal({tag, " mute@12"}, int'(o_dac_mute), 0);
        end
        checkVal({tag, " sel"}, int'(o_filter_select), 7);
    endtask

    initial begin
        int idx;
        vecs[0]  = '{32'd523449139, 3'd0};
        vecs[1]  = '{32'd523449138, 3'd1};
        vecs[2]  = '{32'd289462899, 3'd1};
        vecs[3]  = '{32'd289462898, 3'd2};
        vecs[4]  = '{32'd171351299, 3'd2};
        vecs[5]  = '{32'd171351298, 3'd3};
        vecs[6]  = '{32'd101558080, 3'd3};
        vecs[7]  = '{32'd101558079, 3'd4};
        vecs[8]  = '{32'd63977116,  3'd4};
        vecs[9]  = '{32'd63977115,  3'd5};
        vecs[10] = '{32'd40712710,  3'd5};
        vecs[11] = '{32'd40712709,  3'd6};
        vecs[12] = '{32'hFFFFFFFF,  3'd0};
        vecs[13] = '{32'd0,         3'd7};
        vecs[14] = '{32'd26396152,  3'd7};
        vecs[15] = '{32'd8947849,   3'd7};

        // Power-up at 1 MHz
        modelReset();
        applyStimulus(32'd8947849, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        powerUp("powerup");

        // One-cycle glitch into band 1 must not start a switch
        applyStimulus(32'd40000000, 1'b0);
        tick("glitch");
        checkVal("glitch busy rise", int'(o_busy), 1);
        applyStimulus(32'd8947849, 1'b0);
        tick("glitch");
        checkVal("glitch busy fall", int'(o_busy), 0);
        tick("glitch");
        checkVal("glitch mute", int'(o_dac_mute), 0);
        checkVal("glitch sel", int'(o_filter_select), 7);

        // Candidate switches from band 1 to band 3 mid-qualification
        applyStimulus(32'd40000000, 1'b0);
        tick("cand");
        applyStimulus(32'd70000000, 1'b0);
        tick("cand");
        checkVal("cand restart mute", int'(o_dac_mute), 0);
        tick("cand");
        checkVal("cand mute", int'(o_dac_mute), 1);
        repeat (14) tick("cand");
        checkVal("cand sel", int'(o_filter_select), 4);

        // Band-edge table
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].freq, 1'b0);
            repeat (20) tick("table");
            checkVal($sformatf("table[%0d] sel", i), int'(o_filter_select), int'(vecs[i].expSel));
        end

        // Full sequence timing for the band 0 -> 1 edge
        applyStimulus(32'd26396153, 1'b0);
        for (int r = 1; r <= 16; r++) begin
            tick("timing");
            if (r == 1)  checkVal("timing qual mute", int'(o_dac_mute), 0);
            if (r == 2)  checkVal("timing t0 mute", int'(o_dac_mute), 1);
            if (r == 4)  checkVal("timing t0+2 relay", int'(o_relay_en), 1);
            if (r == 5)  checkVal("timing t0+3 relay", int'(o_relay_en), 0);
            if (r == 8)  checkVal("timing t0+6 sel", int'(o_filter_select), 7);
            if (r == 9)  checkVal("timing t0+7 sel", int'(o_filter_select), 6);
            if (r == 9)  checkVal("timing t0+7 relay", int'(o_relay_en), 0);
            if (r == 10) checkVal("timing t0+8 relay", int'(o_relay_en), 1);
            if (r == 14) checkVal("timing t0+12 done", int'(o_switch_done), 0);
            if (r == 15) checkVal("timing t0+13 done", int'(o_switch_done), 1);
            if (r == 15) checkVal("timing t0+13 mute", int'(o_dac_mute), 0);
            if (r == 16) checkVal("timing idle busy", int'(o_busy), 0);
        end

        // HOLD blocks a new switch; FREQW moved during BREAK waits its turn
        applyStimulus(32'd110000000, 1'b1);
        repeat (6) tick("hold");
        checkVal("hold busy", int'(o_busy), 0);
        checkVal("hold sel", int'(o_filter_select), 6);
        applyStimulus(32'd110000000, 1'b0);
        repeat (5) tick("hold");
        applyStimulus(32'd8947849, 1'b0);
        for (int r = 6; r <= 16; r++) begin
            tick("hold");
            if (r == 15) checkVal("hold done", int'(o_switch_done), 1);
            if (r == 15) checkVal("hold sel band4", int'(o_filter_select), 3);
            if (r == 16) checkVal("hold requal busy", int'(o_busy), 1);
            if (r == 16) checkVal("hold requal mute", int'(o_dac_mute), 0);
        end
        repeat (15) tick("hold");
        checkVal("hold second sel", int'(o_filter_select), 7);

        // Asynchronous reset in the middle of BREAK
        applyStimulus(32'd523449139, 1'b0);
        repeat (17) tick("prereset");
        checkVal("prereset sel", int'(o_filter_select), 0);
        applyStimulus(32'd8947849, 1'b0);
        repeat (6) tick("prereset");
        checkVal("prereset in break relay", int'(o_relay_en), 0);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("async reset");
        @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;
        powerUp("rerun");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, 6));
                case ($urandom_range(0, 2))
                    0: freqw = $urandom();
                    1: freqw = edgesTab[idx];
                    default: freqw = edgesTab[idx] - 32'd1;
                endcase
            end
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
